// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: write port, two read ports, debug counter.
// The master drives addresses and write data; the slave (register file) returns read data.
interface reg_file_2r1w_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr1;
    logic [ADDR_WIDTH-1:0] rd_addr2;
    logic [DATA_WIDTH-1:0] rd_data1;
    logic [DATA_WIDTH-1:0] rd_data2;
    logic [7:0]            wr_count;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, wr_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
        output rd_data1, rd_data2, wr_count
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// 32x32 register file, two combinational read ports with write-through bypass,
// r0 hardwired to zero, saturating debug count of committed writes.
module reg_file_2r1w_rd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                                       i_reset,
    input  logic                                       i_wr_en,
    input  logic [ADDR_WIDTH-1:0]                      i_wr_addr,
    input  logic [DATA_WIDTH-1:0]                      i_wr_data,
    input  logic [ADDR_WIDTH-1:0]                      i_rd_addr,
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] i_regs,
    output logic [DATA_WIDTH-1:0]                      o_rd_data
);
    // Index 0 and reset force zero before any bypass is considered.
    always_comb begin
        o_rd_data = '0;
        if (!i_reset && (i_rd_addr != '0)) begin
            if (i_wr_en && (i_wr_addr == i_rd_addr))
                o_rd_data = i_wr_data;
            else
                o_rd_data = i_regs[i_rd_addr];
        end
    end
endmodule

module reg_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              clk,
    input  logic              reset,
    reg_file_2r1w_if.slave    bus
);
    localparam int NREG  = 2**ADDR_WIDTH;
    localparam int NRD   = 2;

    logic [NREG-1:0][DATA_WIDTH-1:0] r_regs;
    logic [7:0]                      r_wr_count;
    logic                            w_commit;
    logic [NRD-1:0][ADDR_WIDTH-1:0]  w_rd_addr;
    logic [NRD-1:0][DATA_WIDTH-1:0]  w_rd_data;

    assign w_commit = bus.wr_en && (bus.wr_addr != '0);

    // r_regs[0] is only ever written by reset, so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regs     <= '0;
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
            if (r_wr_count != 8'hFF)
                r_wr_count <= r_wr_count + 8'd1;
        end
    end

    assign w_rd_addr[0] = bus.rd_addr1;
    assign w_rd_addr[1] = bus.rd_addr2;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        reg_file_2r1w_rd #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rd (
            .i_reset   (reset),
            .i_wr_en   (bus.wr_en),
            .i_wr_addr (bus.wr_addr),
            .i_wr_data (bus.wr_data),
            .i_rd_addr (w_rd_addr[g]),
            .i_regs    (r_regs),
            .o_rd_data (w_rd_data[g])
        );
    end

    assign bus.rd_data1 = w_rd_data[0];
    assign bus.rd_data2 = w_rd_data[1];
    assign bus.wr_count = r_wr_count;
endmodule
